// File: rtl/parity_frame_checker.sv
// Serial parity checker for framed bit streams with sof realignment and one-cycle result pulses.
// Optional saturating parity-error counter built when PARITY_ERR_CNT_EN is defined.
module parity_frame_checker #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned ERR_CNT_W = 8,
    localparam int unsigned CNT_W    = $clog2(FRAME_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_in,
    input  logic                 valid,
    input  logic                 sof,
    input  logic                 mode,
    input  logic                 clear_err,
    output logic [CNT_W-1:0]     bit_count,
    output logic                 result_valid,
    output logic                 parity_ok,
    output logic                 parity_err,
    output logic                 frame_abort,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_bit_count;
    logic [CNT_W-1:0] w_bit_count_nxt;
    logic             r_acc;
    logic             w_acc_nxt;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             w_done;
    logic             w_match;
    logic             w_abort;
    logic             r_result_valid;
    logic             r_parity_ok;
    logic             r_parity_err;
    logic             r_frame_abort;

    // State, counter, accumulator and latched mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_count <= '0;
            r_acc       <= 1'b0;
            r_mode      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_count <= w_bit_count_nxt;
            r_acc       <= w_acc_nxt;
            r_mode      <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_count_nxt = r_bit_count;
        w_acc_nxt       = r_acc;
        w_mode_nxt      = r_mode;
        w_done          = 1'b0;
        w_match         = 1'b0;
        w_abort         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid) begin
                    w_acc_nxt       = data_in;
                    w_mode_nxt      = mode;
                    w_bit_count_nxt = CNT_W'(1);
                    w_state_nxt     = S_RUN;
                end
            end
            S_RUN: begin
                if (valid && sof) begin
                    // Realign: current bit opens a fresh frame
                    w_abort         = 1'b1;
                    w_acc_nxt       = data_in;
                    w_mode_nxt      = mode;
                    w_bit_count_nxt = CNT_W'(1);
                end else if (valid) begin
                    if (r_bit_count == LAST_IDX) begin
                        w_done          = 1'b1;
                        w_match         = ((r_acc ^ data_in) == r_mode);
                        w_acc_nxt       = 1'b0;
                        w_bit_count_nxt = '0;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        w_acc_nxt       = r_acc ^ data_in;
                        w_bit_count_nxt = r_bit_count + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One-cycle result/abort pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result_valid <= 1'b0;
            r_parity_ok    <= 1'b0;
            r_parity_err   <= 1'b0;
            r_frame_abort  <= 1'b0;
        end else begin
            r_result_valid <= w_done;
            r_parity_ok    <= w_done & w_match;
            r_parity_err   <= w_done & ~w_match;
            r_frame_abort  <= w_abort;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    // Counts parity_err pulses; clear wins over a coincident pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (clear_err) begin
            r_err_count <= '0;
        end else if (r_parity_err && (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    logic w_unused_clear_err;

    assign w_unused_clear_err = clear_err;
    assign err_count          = '0;
`endif

    assign bit_count    = r_bit_count;
    assign result_valid = r_result_valid;
    assign parity_ok    = r_parity_ok;
    assign parity_err   = r_parity_err;
    assign frame_abort  = r_frame_abort;

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Serial parity checker for framed bit streams, successor to the 8-bit fixed-length even/odd checker.
- Frame length is parametrised. Start-of-frame realignment aborts a partial frame.
- Parity mode is latched per frame. Result and error are reported as one-cycle pulses.
- Sits between the serial receive front-end and the link-error monitor; one instance per serial lane.

Parameters:
- FRAME_LEN, 8, bits per frame including the trailing parity bit; legal range 2..64.
- CNT_W, $clog2(FRAME_LEN+1), width of bit_count; derived, not overridden.
- ERR_CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  1  serial data bit; sampled only when valid=1.
- valid  input  1  qualifies data_in for the current cycle.
- sof  input  1  start of frame; meaningful only with valid=1.
- mode  input  1  0=even parity, 1=odd parity; latched on the first bit of each frame.
- clear_err  input  1  synchronous clear of err_count.
- bit_count  output  CNT_W  bits accepted in the current frame, 0..FRAME_LEN-1.
- result_valid  output  1  one-cycle pulse: a frame just completed.
- parity_ok  output  1  one-cycle pulse: completed frame parity matched the latched mode.
- parity_err  output  1  one-cycle pulse: completed frame parity mismatched.
- frame_abort  output  1  one-cycle pulse: partial frame discarded by sof.
- err_count  output  ERR_CNT_W  saturating count of parity_err pulses.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, bit_count=0, accumulator=0, latched mode=0. All pulse outputs are 0 and err_count=0.
- State machine has two states, IDLE and RUN.
- IDLE:
  - A valid bit (sof ignored) starts a frame: accumulator<=data_in, mode latched, bit_count<=1, go to RUN.
  - If FRAME_LEN were 1 the frame would complete here; FRAME_LEN>=2, so this never occurs.
- RUN, valid=1, sof=0:
  - accumulator<=accumulator^data_in; bit_count increments.
  - On the FRAME_LEN-th bit the frame completes: bit_count<=0, go to IDLE.
  - The next cycle drives result_valid=1 and exactly one of parity_ok or parity_err.
  - The final XOR includes the bit accepted that cycle.
  - Parity result: total XOR==latched mode gives parity_ok=1, otherwise parity_err=1.
- RUN, valid=1, sof=1:
  - Pulse frame_abort next cycle; no result pulse.
  - The current bit becomes bit 1 of a new frame: accumulator<=data_in, mode re-latched, bit_count<=1, stay in RUN.
- valid=0: state, bit_count and accumulator hold; pulse outputs are 0 the next cycle. Gaps of any length are allowed mid-frame.
- Latency: the result pulse appears on the cycle after the final bit's clock edge. Back-to-back frames with valid held high are supported with no bubble.
- mode changes mid-frame have no effect until the next frame's first bit.
- err_count:
  - Increments on each parity_err, saturating at 2^ERR_CNT_W-1.
  - clear_err has priority over increment in the same cycle; err_count reads 0 the next cycle.
- All pulse outputs are mutually exclusive in any cycle, except result_valid, which is always paired with parity_ok or parity_err.
- Reset mid-frame discards the frame immediately; no pulses are generated.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined: err_count and clear_err behave as above.
- Undefined: the counter logic is not built. err_count is tied to 0 and clear_err is ignored; all other behaviour is unchanged.

Test Plan:
- FRAME_LEN=8, mode=0, valid continuous, bits 1,0,1,1,0,0,0,1 (four 1s) -> result_valid=1 and parity_ok=1 one cycle after the 8th bit; parity_err=0.
- Same bits with mode=1 latched at the first bit -> parity_err=1, parity_ok=0, err_count 0->1.
- 3 bits accepted, then valid=1 with sof=1 -> frame_abort=1 next cycle with no result_valid; bit_count=1, and a following 7 bits complete a new frame.
- Frame with valid=0 gaps of 0,3,1,5 cycles between bits -> bit_count holds during gaps; result identical to the gap-free frame.
- ERR_CNT_W=2, five bad frames -> err_count 1,2,3,3,3. clear_err asserted together with a sixth parity_err -> err_count=0.
- Reset asserted after bit 5 -> all outputs 0 immediately. A full 8-bit frame after release gives a correct result; no stray pulse from the aborted frame.
